// File: rtl/bus_demux4_pkg.sv
// Shared definitions for the bus_demux4 load/store router.
//   state_t      : FSM state encoding (IDLE=0, REQ=1, RESP=2, DONE=3)
//   NUM_TGT      : number of downstream targets
//   DEF_BASE*/DEF_MASK* : default address regions (RAM, UART, timer, GPIO)
package bus_demux4_pkg;

    localparam int NUM_TGT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEF_BASE0 = 32'h0000_0000;
    localparam logic [31:0] DEF_MASK0 = 32'hFFFF_0000;
    localparam logic [31:0] DEF_BASE1 = 32'h1000_0000;
    localparam logic [31:0] DEF_MASK1 = 32'hFFFF_F000;
    localparam logic [31:0] DEF_BASE2 = 32'h2000_0000;
    localparam logic [31:0] DEF_MASK2 = 32'hFFFF_F000;
    localparam logic [31:0] DEF_BASE3 = 32'h3000_0000;
    localparam logic [31:0] DEF_MASK3 = 32'hFFFF_F000;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder for bus_demux4.
//   addr : address to decode
//   base : per-target region base, target i at base[i]
//   mask : per-target region mask, target i at mask[i]
//   sel  : index of the matching target (lowest index wins on overlap)
//   hit  : 1 when any region matched
module bus_addr_decode
    import bus_demux4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]              addr,
    input  logic [NUM_TGT-1:0][WIDTH-1:0] base,
    input  logic [NUM_TGT-1:0][WIDTH-1:0] mask,
    output logic [1:0]                    sel,
    output logic                          hit
);

    // Scan from the highest index down so the lowest matching index
    // overwrites the others and wins.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if ((addr & mask[i]) == base[i]) begin
                sel = 2'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_demux4.sv
// One-initiator, four-target bus router for the LSU data path.
// Accepts one request, decodes it to a target region, runs that target's
// request/response handshake and returns a single registered response.
// Unmapped addresses get an immediate error response.
//   clk, rst_n            : clock, synchronous active-low reset
//   m_valid/m_ready       : initiator request handshake
//   m_addr/m_wdata/m_we/m_be : initiator request payload
//   m_rvalid/m_rdata/m_err   : initiator response (one-cycle pulse)
//   s_valid/s_ready       : per-target request handshake (one-hot)
//   s_addr/s_wdata/s_we/s_be : shared latched request payload
//   s_rvalid/s_rdata      : per-target response, target i at [i*WIDTH +: WIDTH]
module bus_demux4
    import bus_demux4_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] BASE0 = WIDTH'(DEF_BASE0),
    parameter logic [WIDTH-1:0] MASK0 = WIDTH'(DEF_MASK0),
    parameter logic [WIDTH-1:0] BASE1 = WIDTH'(DEF_BASE1),
    parameter logic [WIDTH-1:0] MASK1 = WIDTH'(DEF_MASK1),
    parameter logic [WIDTH-1:0] BASE2 = WIDTH'(DEF_BASE2),
    parameter logic [WIDTH-1:0] MASK2 = WIDTH'(DEF_MASK2),
    parameter logic [WIDTH-1:0] BASE3 = WIDTH'(DEF_BASE3),
    parameter logic [WIDTH-1:0] MASK3 = WIDTH'(DEF_MASK3)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [WIDTH-1:0]           m_addr,
    input  logic [WIDTH-1:0]           m_wdata,
    input  logic                       m_we,
    input  logic [3:0]                 m_be,
    output logic                       m_rvalid,
    output logic [WIDTH-1:0]           m_rdata,
    output logic                       m_err,
    output logic [NUM_TGT-1:0]         s_valid,
    input  logic [NUM_TGT-1:0]         s_ready,
    output logic [WIDTH-1:0]           s_addr,
    output logic [WIDTH-1:0]           s_wdata,
    output logic                       s_we,
    output logic [3:0]                 s_be,
    input  logic [NUM_TGT-1:0]         s_rvalid,
    input  logic [NUM_TGT*WIDTH-1:0]   s_rdata
);

    localparam logic [NUM_TGT-1:0][WIDTH-1:0] BASES = {BASE3, BASE2, BASE1, BASE0};
    localparam logic [NUM_TGT-1:0][WIDTH-1:0] MASKS = {MASK3, MASK2, MASK1, MASK0};

    state_t           state, state_next;
    logic [1:0]       sel;
    logic             hit;
    logic             err;
    logic [1:0]       dec_sel;
    logic             dec_hit;
    logic [WIDTH-1:0] rdata_sel;

    bus_addr_decode #(.WIDTH(WIDTH)) u_dec (
        .addr (m_addr),
        .base (BASES),
        .mask (MASKS),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    assign rdata_sel = s_rdata[sel*WIDTH +: WIDTH];

    // Next state and handshake outputs. m_ready is gated by rst_n so a
    // request presented during reset is never accepted.
    always_comb begin
        state_next = state;
        s_valid    = '0;
        m_ready    = 1'b0;
        case (state)
            IDLE: begin
                m_ready = rst_n;
                if (m_valid) state_next = dec_hit ? REQ : DONE;
            end
            REQ: begin
                s_valid[sel] = hit;
                if (s_ready[sel]) state_next = RESP;
            end
            RESP: begin
                if (s_rvalid[sel]) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // m_rvalid/m_err are loaded on the edge entering DONE so they are
    // registered and high only while the FSM sits in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_addr   <= '0;
            s_wdata  <= '0;
            s_we     <= 1'b0;
            s_be     <= '0;
            sel      <= '0;
            hit      <= 1'b0;
            err      <= 1'b0;
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
            m_rdata  <= '0;
        end else begin
            state    <= state_next;
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_we    <= m_we;
                        s_be    <= m_be;
                        sel     <= dec_sel;
                        hit     <= dec_hit;
                        if (!dec_hit) begin
                            err      <= 1'b1;
                            m_rdata  <= '0;
                            m_rvalid <= 1'b1;
                            m_err    <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (s_rvalid[sel]) begin
                        m_rdata  <= rdata_sel;
                        err      <= 1'b0;
                        m_rvalid <= 1'b1;
                        m_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bus_demux4.md
Name: bus_demux4

Overview:
- One-initiator, four-target data-bus router for the core's load/store path.
- Accepts one request from the LSU, decodes its address into one of four target regions, and drives that target's request handshake.
- Returns the selected target's read data to the initiator, and generates an error response for unmapped addresses.
- One outstanding transaction at a time; all initiator-side outputs are registered.

Parameters:
WIDTH, 32, data and address width
BASE0, 32'h0000_0000, target 0 (data RAM) region base
MASK0, 32'hFFFF_0000, target 0 region mask
BASE1, 32'h1000_0000, target 1 (UART) base
MASK1, 32'hFFFF_F000, target 1 mask
BASE2, 32'h2000_0000, target 2 (timer) base
MASK2, 32'hFFFF_F000, target 2 mask
BASE3, 32'h3000_0000, target 3 (GPIO) base
MASK3, 32'hFFFF_F000, target 3 mask

Ports:
clk  in  1  clock; sole clock domain
rst_n  in  1  synchronous active-low reset
m_valid  in  1  initiator request valid
m_ready  out  1  initiator request accept
m_addr  in  WIDTH  request address
m_wdata  in  WIDTH  write data
m_we  in  1  1=write, 0=read
m_be  in  4  byte enables
m_rvalid  out  1  response valid (one-cycle pulse)
m_rdata  out  WIDTH  response read data
m_err  out  1  response is a decode error; qualified by m_rvalid
s_valid  out  4  per-target request valid, one-hot or zero
s_ready  in  4  per-target request accept
s_addr  out  WIDTH  shared latched address
s_wdata  out  WIDTH  shared latched write data
s_we  out  1  shared latched write enable
s_be  out  4  shared latched byte enables
s_rvalid  in  4  per-target response valid
s_rdata  in  4*WIDTH  per-target read data; target i occupies bits [i*WIDTH +: WIDTH]

Behaviour:
- Decode: target i hits when (addr & MASKi) == BASEi. On multiple hits the lowest index wins. No hit means unmapped.
- Handshake: a transfer occurs on a cycle where valid and ready are both 1.
- FSM states: IDLE, REQ, RESP, DONE. The state register and all datapath registers update on the rising edge of clk.
- IDLE:
  - m_ready = 1; this is the only state with m_ready = 1.
  - On m_valid, latch addr/wdata/we/be into the s_* registers and latch sel plus a hit flag.
  - On a hit, go to REQ. On a miss, set err = 1 and rdata = 0, then go to DONE.
- REQ:
  - s_valid[sel] = 1; all other s_valid bits are 0.
  - On s_ready[sel], go to RESP. Otherwise hold, with the s_* outputs stable.
- RESP:
  - All s_valid bits are 0.
  - On s_rvalid[sel], register s_rdata[sel] into m_rdata, set err = 0, and go to DONE.
  - s_rvalid from unselected targets is ignored.
  - Targets must not assert s_rvalid in the same cycle as their s_ready acceptance; the block only samples s_rvalid in RESP.
- DONE: m_rvalid = 1 for exactly one cycle, with m_err = err, then go to IDLE.
- Every transaction, read or write, gets exactly one m_rvalid pulse. Writes return m_rdata = the target's s_rdata (don't-care to the initiator).
- Timing for a mapped target with zero wait states:
  - accept at cycle 0, s_valid and s_ready at cycle 1, s_rvalid at cycle 2, m_rvalid at cycle 3, m_ready again at cycle 4.
  - Request-to-response latency is 3 cycles; back-to-back throughput is 1 transaction per 4 cycles.
- Timing for an unmapped address: accept at cycle 0, m_rvalid with m_err = 1 at cycle 1, m_ready at cycle 2. No s_valid bit is ever asserted.
- Reset:
  - While rst_n = 0 at a clock edge, the next state is IDLE and m_rvalid, m_err, m_rdata, s_addr, s_wdata, s_we, s_be, sel and err all become 0.
  - m_ready is gated: m_ready = (state == IDLE) && rst_n, so nothing is accepted during reset.
  - Reset mid-transaction, in any state, abandons the transaction: no m_rvalid is produced, and s_valid drops on the next edge.
- m_valid is ignored outside IDLE. The initiator must hold its request until m_ready.

Decomposition:
- Shared package: the FSM state encoding (2-bit: IDLE=0, REQ=1, RESP=2, DONE=3), the default region BASE/MASK constants, and a target count of 4.
- One natural sub-module: bus_addr_decode, a combinational block that takes addr, BASE0..3 and MASK0..3 and produces sel[1:0] plus hit, with lowest-index priority.

Test Plan:
- Read from 32'h0000_0040, target 0 with zero wait states and s_rdata0 = 32'hDEAD_BEEF -> s_valid = 4'b0001 at cycle 1; m_rvalid with m_rdata = 32'hDEAD_BEEF and m_err = 0 at cycle 3.
- Write to 32'h1000_0004 with wdata 32'h41, be 4'hF; s_ready1 held low for 3 cycles -> s_valid = 4'b0010 and s_addr/s_wdata stable for 4 cycles; exactly one m_rvalid pulse after s_rvalid1.
- Read from 32'h4000_0000 (unmapped) -> m_rvalid = 1, m_err = 1, m_rdata = 0 at cycle 1; s_valid stays 4'b0000 throughout.
- In RESP for target 2, assert s_rvalid0 and s_rvalid3 first, then s_rvalid2 with s_rdata2 = 32'h1234 -> the stray responses are ignored; m_rdata = 32'h1234.
- Assert rst_n = 0 for 1 cycle while in REQ -> s_valid = 0 at the next edge, no m_rvalid, m_ready = 1 once rst_n = 1.
- Overlapping regions: MASK1 = 0, BASE1 = 0, read 32'h0000_0010 -> target 0 is selected (s_valid = 4'b0001).
